// File: rtl/logic_function_sweeper_if.sv
// logic_function_sweeper_if
// Groups the sweep controller's signals: the test-control handshake
// (start/abort, busy/done, results) and the drive/sense lines to the
// 3-input combinational block (a_out/b_out/c_out out, f_in back).
//   slave  : the sweeper itself
//   master : test control plus the block under control (bench side)
interface logic_function_sweeper_if;
   logic       start;
   logic       abort;
   logic       f_in;
   logic       a_out;
   logic       b_out;
   logic       c_out;
   logic       busy;
   logic       done;
   logic [7:0] truth_table;
   logic       pass;
   logic [3:0] fail_count;
   logic [2:0] first_fail_idx;

   modport slave (
      input  start, abort, f_in,
      output a_out, b_out, c_out, busy, done, truth_table, pass,
             fail_count, first_fail_idx
   );

   modport master (
      output start, abort, f_in,
      input  a_out, b_out, c_out, busy, done, truth_table, pass,
             fail_count, first_fail_idx
   );
endinterface

// File: rtl/logic_function_sweeper.sv
// logic_function_sweeper
// Built-in self-test sequencer for the 3-input logic_function block.
// On start it drives {A,B,C} through 0..7, holds each vector SETTLE_CYCLES
// cycles, samples F for one cycle, builds an 8-bit truth table and compares
// it with EXPECTED (fail count, lowest failing index, pass flag).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave modport -- start/abort/f_in in; a/b/c drive, busy,
//            done pulse, truth_table, pass, fail_count, first_fail_idx out
// All outputs come straight from flops.
module logic_function_sweeper #(
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [7:0] EXPECTED      = 8'h1D
) (
   input logic                     clk,
   input logic                     rst_n,
   logic_function_sweeper_if.slave bus
);

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

   state_t     state, stateNxt;
   logic [2:0] idx, idxNxt;
   logic [3:0] cnt, cntNxt;
   logic       busy, busyNxt;
   logic       done, doneNxt;
   logic [7:0] truthTable, truthTableNxt;
   logic       pass, passNxt;
   logic [3:0] failCount, failCountNxt;
   logic [2:0] firstFail, firstFailNxt;
   logic       miss;

   // idx is held at 0 outside a sweep, so it doubles as the registered drive.
   assign bus.a_out          = idx[2];
   assign bus.b_out          = idx[1];
   assign bus.c_out          = idx[0];
   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.truth_table    = truthTable;
   assign bus.pass           = pass;
   assign bus.fail_count     = failCount;
   assign bus.first_fail_idx = firstFail;

   assign miss = (bus.f_in != EXPECTED[idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         truthTable <= '0;
         pass       <= 1'b0;
         failCount  <= '0;
         firstFail  <= '0;
      end else begin
         state      <= stateNxt;
         idx        <= idxNxt;
         cnt        <= cntNxt;
         busy       <= busyNxt;
         done       <= doneNxt;
         truthTable <= truthTableNxt;
         pass       <= passNxt;
         failCount  <= failCountNxt;
         firstFail  <= firstFailNxt;
      end
   end

   always_comb begin
      stateNxt      = state;
      idxNxt        = idx;
      cntNxt        = cnt;
      busyNxt       = busy;
      doneNxt       = 1'b0;
      truthTableNxt = truthTable;
      passNxt       = pass;
      failCountNxt  = failCount;
      firstFailNxt  = firstFail;

      if (state != IDLE && bus.abort) begin
         // Abort clears everything back to reset values, no done pulse.
         stateNxt      = IDLE;
         idxNxt        = '0;
         cntNxt        = '0;
         busyNxt       = 1'b0;
         truthTableNxt = '0;
         passNxt       = 1'b0;
         failCountNxt  = '0;
         firstFailNxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               // abort beats start; start while busy never reaches here.
               if (bus.start && !bus.abort) begin
                  stateNxt      = SETTLE;
                  idxNxt        = '0;
                  cntNxt        = '0;
                  busyNxt       = 1'b1;
                  truthTableNxt = '0;
                  passNxt       = 1'b0;
                  failCountNxt  = '0;
                  firstFailNxt  = '0;
               end
            end
            SETTLE: begin
               if (cnt == CNT_LAST) stateNxt = SAMPLE;
               else                 cntNxt   = cnt + 4'd1;
            end
            SAMPLE: begin
               truthTableNxt[idx] = bus.f_in;
               if (miss) begin
                  failCountNxt = failCount + 4'd1;
                  if (failCount == 4'd0) firstFailNxt = idx;
               end
               if (idx == 3'd7) begin
                  stateNxt = IDLE;
                  idxNxt   = '0;
                  cntNxt   = '0;
                  busyNxt  = 1'b0;
                  doneNxt  = 1'b1;
                  // Uses the count including index 7.
                  passNxt  = (failCountNxt == 4'd0);
               end else begin
                  stateNxt = SETTLE;
                  idxNxt   = idx + 3'd1;
                  cntNxt   = '0;
               end
            end
            default: stateNxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_function_sweeper.sv
// Directed bench for logic_function_sweeper with S=2, EXPECTED=8'h1D.
// f_in comes from a model of F = A'B + B'C' + A'BC, or is forced 1 / 0.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_logic_function_sweeper;

   logic clk;
   logic rst_n;
   logic clkEn;
   int   mode;   // 0 real block, 1 stuck-at-1, 2 stuck-at-0
   int   checks;
   int   errors;
   logic fModel;

   logic_function_sweeper_if bus ();

   logic_function_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(8'h1D)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   assign fModel = (!bus.a_out && bus.b_out) || (!bus.b_out && !bus.c_out) ||
                   (!bus.a_out && bus.b_out && bus.c_out);
   assign bus.f_in = (mode == 0) ? fModel : (mode == 1);

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clkEn) clk = ~clk;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chkReset(input string tag);
      chk({tag, ".abc"},   {bus.a_out, bus.b_out, bus.c_out}, 0);
      chk({tag, ".busy"},  bus.busy, 0);
      chk({tag, ".done"},  bus.done, 0);
      chk({tag, ".tt"},    bus.truth_table, 0);
      chk({tag, ".pass"},  bus.pass, 0);
      chk({tag, ".fcnt"},  bus.fail_count, 0);
      chk({tag, ".first"}, bus.first_fail_idx, 0);
   endtask

   // Pulse start for one edge (E0); returns at the falling edge after E0.
   task automatic kick();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // At falling edge c after E0: vector c/3 held, busy, no done.
   task automatic stepCheck(input int c);
      chk("abc",  {bus.a_out, bus.b_out, bus.c_out}, c / 3);
      chk("busy", bus.busy, 1);
      chk("done", bus.done, 0);
      @(negedge clk);
   endtask

   task automatic endCheck(input logic [7:0] tt, input logic ps,
                           input logic [3:0] fc, input logic [2:0] ff);
      chk("end.done",  bus.done, 1);
      chk("end.busy",  bus.busy, 0);
      chk("end.abc",   {bus.a_out, bus.b_out, bus.c_out}, 0);
      chk("end.tt",    bus.truth_table, tt);
      chk("end.pass",  bus.pass, ps);
      chk("end.fcnt",  bus.fail_count, fc);
      chk("end.first", bus.first_fail_idx, ff);
      @(negedge clk);
      chk("post.done", bus.done, 0);
      chk("post.tt",   bus.truth_table, tt);
      chk("post.pass", bus.pass, ps);
   endtask

   task automatic fullSweep(input logic [7:0] tt, input logic ps,
                            input logic [3:0] fc, input logic [2:0] ff);
      kick();
      for (int c = 0; c < 24; c++) stepCheck(c);
      endCheck(tt, ps, fc, ff);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      mode      = 0;
      clkEn     = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst_n     = 1'b1;

      // Reset with the clock stopped.
      #2 rst_n = 1'b0;
      #1 chkReset("rst");
      #10 rst_n = 1'b1;
      clkEn = 1'b1;
      repeat (10) @(negedge clk);
      chkReset("idle10");

      // Good sweep against the real block.
      mode = 0;
      fullSweep(8'h1D, 1'b1, 4'd4 - 4'd4, 3'd0);

      // Stuck-at-1 and stuck-at-0.
      mode = 1;
      fullSweep(8'hFF, 1'b0, 4'd4, 3'd1);
      mode = 2;
      fullSweep(8'h00, 1'b0, 4'd4, 3'd0);

      // Start re-pulsed at vector 2, then abort during vector 3.
      mode = 1;
      kick();
      for (int c = 0; c < 6; c++) stepCheck(c);
      bus.start = 1'b1;
      stepCheck(6);
      bus.start = 1'b0;
      for (int c = 7; c < 9; c++) stepCheck(c);
      chk("preabort.tt",   bus.truth_table, 8'h07);
      chk("preabort.fcnt", bus.fail_count, 1);
      bus.abort = 1'b1;
      stepCheck(9);
      bus.abort = 1'b0;
      chkReset("abort");
      for (int i = 0; i < 30; i++) begin
         chk("abort.nodone", bus.done, 0);
         @(negedge clk);
      end

      // start+abort together in IDLE: no sweep.
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("sa.busy", bus.busy, 0);
         chk("sa.abc",  {bus.a_out, bus.b_out, bus.c_out}, 0);
         @(negedge clk);
      end

      // Clean start afterwards.
      mode = 0;
      fullSweep(8'h1D, 1'b1, 4'd0, 3'd0);

      // Reset mid-sweep at vector 5, between edges.
      mode = 2;
      kick();
      for (int c = 0; c < 15; c++) stepCheck(c);
      chk("v5.abc", {bus.a_out, bus.b_out, bus.c_out}, 5);
      #2 rst_n = 1'b0;
      #1 chkReset("midrst");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chkReset("midrst.hold");
      end
      rst_n = 1'b1;
      @(negedge clk);
      chkReset("midrst.rel");

      mode = 0;
      fullSweep(8'h1D, 1'b1, 4'd0, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
